// File: rtl/serializer.sv
// Wide-to-narrow converter: pops wide words from an upstream FWFT FIFO and pushes them
// downstream as out_bit_width segments, least-significant segment first.
module serializer #(
    parameter int in_bit_width  = 512,
    parameter int out_bit_width = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_ready,
    output logic                     read_data,
    input  logic [in_bit_width-1:0]  data_in,
    input  logic                     space_available,
    output logic                     write_data,
    output logic [out_bit_width-1:0] data_out,
    output logic                     idle
);

    localparam int n_seg = in_bit_width / out_bit_width;
    localparam int cnt_w = (n_seg > 1) ? $clog2(n_seg) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(n_seg - 1);

    logic [in_bit_width-1:0] pbuf;
    logic                    pvalid;
    logic [in_bit_width-1:0] sreg;
    logic                    busy;
    logic [cnt_w-1:0]        cnt;

    // Strobes are gated by reset so nothing moves on a reset edge.
    assign read_data  = !reset && data_ready && !pvalid;
    assign write_data = !reset && busy && space_available;
    assign data_out   = sreg[out_bit_width-1:0];
    assign idle       = !pvalid && !busy;

    // NOTE: every register here uses <= so all updates see pre-edge values of
    // pvalid/busy/cnt, which is what makes the pop and the transfer mutually exclusive.
    always_ff @(posedge clk) begin
        if (reset) begin
            pbuf   <= '0;
            pvalid <= 1'b0;
            sreg   <= '0;
            busy   <= 1'b0;
            cnt    <= '0;
        end else begin
            if (write_data) begin
                if (cnt == last_cnt) begin
                    cnt <= '0;
                    // Back-to-back reload from the prefetch avoids a bubble between words.
                    if (pvalid) begin
                        sreg   <= pbuf;
                        pvalid <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end else begin
                    sreg <= sreg >> out_bit_width;
                    cnt  <= cnt + 1'b1;
                end
            end else if (!busy && pvalid) begin
                sreg   <= pbuf;
                pvalid <= 1'b0;
                busy   <= 1'b1;
                cnt    <= '0;
            end

            // A pop only happens while pvalid=0, so it never collides with a transfer above.
            if (read_data) begin
                pbuf   <= data_in;
                pvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: an upstream word source, a segment scoreboard filled on
// each pop and drained on each push, and a reassembly model standing in for the deserializer.
module tb_serializer;

    localparam int IW = 512;
    localparam int W  = 32;
    localparam int N  = IW / W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          data_ready = 1'b0;
    logic          read_data;
    logic [IW-1:0] data_in = '0;
    logic          space_available = 1'b1;
    logic          write_data;
    logic [W-1:0]  data_out;
    logic          idle;

    serializer #(.in_bit_width(IW), .out_bit_width(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_ready      (data_ready),
        .read_data       (read_data),
        .data_in         (data_in),
        .space_available (space_available),
        .write_data      (write_data),
        .data_out        (data_out),
        .idle            (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] src[$];
    logic [IW-1:0] exp_words[$];
    logic [W-1:0]  sb[$];
    logic          src_en = 1'b0;

    int cyc = 0;
    int pops = 0;
    int beats = 0;
    int first_beat = -1;
    int last_beat = -1;
    int pop_cyc = -1;
    int rx_cnt = 0;
    logic [IW-1:0] rx_word = '0;
    logic stall_chk = 1'b0;
    logic depth_chk = 1'b0;

    logic         s_read, s_write, s_idle;
    logic [W-1:0] s_out;

    task automatic check(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] make_word(input int base);
        logic [IW-1:0] w;
        for (int k = 0; k < N; k++) w[k*W +: W] = W'(base + k);
        return w;
    endfunction

    task automatic drive_src();
        data_ready = src_en && (src.size() > 0);
        data_in    = (src.size() > 0) ? src[0] : '0;
    endtask

    task automatic clear_stats();
        pops = 0;
        beats = 0;
        first_beat = -1;
        last_beat = -1;
        pop_cyc = -1;
    endtask

    // One clock: sample at the falling edge, then update the source after the rising edge.
    task automatic step();
        logic [W-1:0] exp_seg;
        @(negedge clk);
        cyc++;
        s_read  = read_data;
        s_write = write_data;
        s_idle  = idle;
        s_out   = data_out;
        check("write_gate", write_data && !space_available, 1'b0);
        if (read_data) begin
            if (pop_cyc < 0) pop_cyc = cyc;
            pops++;
            exp_words.push_back(data_in);
            for (int k = 0; k < N; k++) sb.push_back(data_in[k*W +: W]);
        end
        if (write_data) begin
            beats++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            check("beat_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp_seg = sb.pop_front();
                check("data_out", data_out, exp_seg);
                rx_word[rx_cnt*W +: W] = data_out;
                rx_cnt++;
                if (rx_cnt == N) begin
                    check("roundtrip", rx_word, exp_words.pop_front());
                    rx_cnt = 0;
                end
            end
        end else if (stall_chk && beats > 0 && sb.size() > 0) begin
            check("stall_hold", data_out, sb[0]);
        end
        if (depth_chk) check("prefetch_depth", sb.size() <= 2 * N, 1'b1);
        @(posedge clk);
        #1;
        if (s_read && src.size() > 0) void'(src.pop_front());
        drive_src();
    endtask

    task automatic run_until_drained(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(sb.size() == 0 && s_idle) && n < budget);
        check("drain_timeout", sb.size() == 0 && s_idle, 1'b1);
    endtask

    initial begin
        int n;

        // 1. Reset with upstream empty.
        reset = 1'b1;
        step();
        step();
        check("rst_read_data", s_read, 1'b0);
        check("rst_write_data", s_write, 1'b0);
        check("rst_idle", s_idle, 1'b1);
        check("rst_data_out", s_out, '0);
        reset = 1'b0;

        // 2. Single word, latency and segment order.
        clear_stats();
        src.push_back(make_word(32'h100));
        src_en = 1'b1;
        drive_src();
        run_until_drained(100);
        check("t2_beats", beats, 16);
        check("t2_latency", first_beat - pop_cyc, 2);
        check("t2_idle", s_idle, 1'b1);

        // 3. Sixteen words back-to-back, gap-free.
        clear_stats();
        for (int i = 0; i < 16; i++) src.push_back(make_word(16 * i));
        drive_src();
        run_until_drained(600);
        check("t3_beats", beats, 256);
        check("t3_gapless", last_beat - first_beat, 255);
        check("t3_pops", pops, 16);

        // 4. Toggling backpressure.
        clear_stats();
        stall_chk = 1'b1;
        depth_chk = 1'b1;
        for (int i = 0; i < 4; i++) src.push_back(make_word(32'h1000 + 16 * i));
        space_available = 1'b1;
        drive_src();
        n = 0;
        do begin
            step();
            space_available = ~space_available;
            n++;
        end while (!(sb.size() == 0 && s_idle && src.size() == 0) && n < 400);
        check("t4_timeout", sb.size() == 0 && s_idle, 1'b1);
        check("t4_beats", beats, 64);
        check("t4_pops", pops, 4);
        stall_chk = 1'b0;
        depth_chk = 1'b0;
        space_available = 1'b1;

        // 5. Reset after segment 5 with a word prefetched.
        clear_stats();
        src.push_back(make_word(32'h2000));
        src.push_back(make_word(32'h3000));
        drive_src();
        n = 0;
        while (beats < 6 && n < 50) begin
            step();
            n++;
        end
        check("t5_reach_seg5", beats, 6);
        check("t5_prefetched", pops, 2);
        reset = 1'b1;
        src_en = 1'b0;
        src.delete();
        sb.delete();
        exp_words.delete();
        rx_cnt = 0;
        drive_src();
        #1;
        check("t5_rst_write", write_data, 1'b0);
        check("t5_rst_read", read_data, 1'b0);
        step();
        reset = 1'b0;
        step();
        check("t5_idle", s_idle, 1'b1);
        check("t5_data_out", s_out, '0);
        clear_stats();
        src.push_back(make_word(32'h4000));
        src_en = 1'b1;
        drive_src();
        run_until_drained(100);
        check("t5_beats", beats, 16);

        // 6. Single-cycle data_ready pulse while busy with an empty prefetch.
        clear_stats();
        src.push_back(make_word(32'h5000));
        drive_src();
        n = 0;
        while (pops < 1 && n < 20) begin
            step();
            n++;
        end
        check("t6_first_pop", pops, 1);
        src_en = 1'b0;
        src.push_back(make_word(32'h6000));
        src.push_back(make_word(32'h7000));
        drive_src();
        n = 0;
        while (beats < 4 && n < 20) begin
            step();
            n++;
        end
        check("t6_busy", beats, 4);
        src_en = 1'b1;
        drive_src();
        step();
        src_en = 1'b0;
        drive_src();
        run_until_drained(100);
        check("t6_pops", pops, 2);
        check("t6_beats", beats, 32);
        check("t6_seamless", last_beat - first_beat, 31);
        check("t6_left_in_src", src.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
